// File: rtl/wb_arbiter.sv
// Writeback arbiter and register scoreboard.
// Two requesters compete for one register-bank write port: A (ALU) and B (load unit).
// The scoreboard tracks which destination registers are still pending writeback.
// Ports:
//   clk, rst                       - clock and synchronous active-high reset
//   a_valid/a_addr/a_data/a_ready  - ALU writeback request and its grant
//   b_valid/b_addr/b_data/b_ready  - load-unit writeback request and its grant
//   write_en/write_addr/write_data - registered register-bank write, one cycle after the handshake
//   issue_en/issue_addr/issue_busy - issue stage marks a destination pending; issue_busy reports it
//   query_addr_A/B, busy_A/B       - decode-stage source lookups; busy means decode must stall
module wb_arbiter #(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        write_en,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data,
    input  logic        issue_en,
    input  logic [4:0]  issue_addr,
    output logic        issue_busy,
    input  logic [4:0]  query_addr_A,
    input  logic [4:0]  query_addr_B,
    output logic        busy_A,
    output logic        busy_B
);
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned NREG = 32;

    typedef enum logic {PRI_A = 1'b0, PRI_B = 1'b1} pri_t;

    pri_t            pri_q, pri_d;
    logic            wr_en_q;
    logic [AW-1:0]   wr_addr_q;
    logic [DW-1:0]   wr_data_q;
    logic [NREG-1:0] busy_q;

    logic            hs;
    logic [AW-1:0]   hs_addr;
    logic [DW-1:0]   hs_data;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    // Priority pointer register
    always_ff @(posedge clk) begin
        if (rst) pri_q <= PRI_A;
        else     pri_q <= pri_d;
    end

    // Grant selection and pointer update
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        pri_d   = pri_q;
        if (!rst) begin
            if (a_valid && b_valid) begin
                if (FIXED_PRI || pri_q == PRI_B) b_ready = 1'b1;
                else                             a_ready = 1'b1;
            end else begin
                a_ready = a_valid;
                b_ready = b_valid;
            end
            if (a_ready)      pri_d = PRI_B;
            else if (b_ready) pri_d = PRI_A;
        end
    end

    assign hs      = a_ready | b_ready;
    assign hs_addr = b_ready ? b_addr : a_addr;
    assign hs_data = b_ready ? b_data : a_data;

    // Writeback register; x0 handshakes complete but never write
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= hs && (hs_addr != '0);
            if (hs && (hs_addr != '0)) begin
                wr_addr_q <= hs_addr;
                wr_data_q <= hs_data;
            end
        end
    end

    // A write pending into a reset cycle is suppressed so it never lands in the bank
    assign write_en   = wr_en_q & ~rst;
    assign write_addr = wr_addr_q;
    assign write_data = wr_data_q;

    // Scoreboard set/clear masks
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_en && (issue_addr != '0)) set_mask = NREG'(1) << issue_addr;
        if (wr_en_q)                        clr_mask = NREG'(1) << wr_addr_q;
    end

    // Scoreboard: set wins over a same-edge clear, bit 0 forced to zero
    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= ((busy_q & ~clr_mask) | set_mask) & ~NREG'(1);
    end

    assign busy_A     = busy_q[query_addr_A];
    assign busy_B     = busy_q[query_addr_B];
    assign issue_busy = busy_q[issue_addr];
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRI, default 0; 0 = round-robin between requesters, 1 = port B (load unit) always wins.
REQ-002 The block SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, master reset; synchronous, active-high.
REQ-004 The block SHALL have port a_valid, input, 1, ALU writeback request.
REQ-005 The block SHALL have port a_addr, input, 5, ALU destination register.
REQ-006 The block SHALL have port a_data, input, 32, ALU result.
REQ-007 The block SHALL have port a_ready, output, 1, ALU request accepted this cycle.
REQ-008 The block SHALL have ports b_valid (input, 1), b_addr (input, 5), b_data (input, 32) and b_ready (output, 1), the same for the load unit.
REQ-009 The block SHALL have port write_en, output, 1, register-bank write enable.
REQ-010 The block SHALL have port write_addr, output, 5, register-bank destination.
REQ-011 The block SHALL have port write_data, output, 32, register-bank data.
REQ-012 The block SHALL have ports issue_en (input, 1) and issue_addr (input, 5), the issue stage marking a destination as pending.
REQ-013 The block SHALL have port issue_busy, output, 1, issue_addr is already pending.
REQ-014 The block SHALL have ports query_addr_A and query_addr_B (input, 5 each), the decode-stage source operands.
REQ-015 The block SHALL have ports busy_A and busy_B (output, 1 each), the queried source is pending; decode must stall.

Function
REQ-016 a_ready and b_ready SHALL be combinational, never both high in one cycle, and each high only when its own valid is high.
REQ-017 A handshake SHALL complete when valid && ready in the same cycle; a requester holds addr/data stable until its handshake completes.
REQ-018 With only one valid high, that requester SHALL be granted.
REQ-019 With both valid and FIXED_PRI=0, the requester named by a 1-bit priority pointer SHALL be granted.
REQ-020 The priority pointer SHALL move to B after an A handshake, move to A after a B handshake, and hold otherwise.
REQ-021 With both valid and FIXED_PRI=1, B SHALL be granted.
REQ-022 A handshake in cycle N SHALL register write_addr/write_data at the closing edge, with write_en high for exactly cycle N+1 (latency 1); with no handshake, write_en is 0 in N+1.
REQ-023 A handshake with addr 0 SHALL complete normally, but write_en SHALL stay 0 (x0 never written).
REQ-024 write_addr/write_data SHALL hold their last values when write_en is 0.
REQ-025 The scoreboard SHALL be a 32-bit busy vector with bit 0 hard-wired 0.
REQ-026 issue_en with issue_addr != 0 SHALL set busy[issue_addr] at the clock edge.
REQ-027 write_en high SHALL clear busy[write_addr] at the edge ending cycle N+1, the same edge the bank captures the data, so a reader in N+2 sees the new value.
REQ-028 If a set and a clear hit the same register on the same edge, the set SHALL win and the bit stays 1.
REQ-029 Issuing to an already-busy register SHALL leave the bit at 1; the first matching write clears it (one bit per register, no count).
REQ-030 busy_A, busy_B and issue_busy SHALL be combinational reads of the busy vector (address 0 reads 0) and SHALL reflect updates from the previous edge only, with no same-cycle bypass.

Reset
REQ-031 While rst is high at a clock edge, write_en SHALL be 0, write_addr 0, write_data 0, the busy vector all 0, and the priority pointer A.
REQ-032 a_ready and b_ready SHALL be 0 while rst is high.
REQ-033 A handshake or issue in a cycle with rst high SHALL be discarded, and a write pending from the prior cycle SHALL NOT be performed after reset.

Verification
REQ-034 Single A request: a_valid=1, a_addr=5, a_data=0xDEADBEEF in cycle 1 -> a_ready=1 in cycle 1; write_en=1, write_addr=5, write_data=0xDEADBEEF in cycle 2 only.
REQ-035 Contention, FIXED_PRI=0: both valid for 3 cycles (A addr 1, B addr 2, neither dropping) -> grants A, B, A; afterward the pointer = B; FIXED_PRI=1 -> grants B every cycle.
REQ-036 Scoreboard round-trip: issue_en to x7 -> busy_A=1 for query_addr_A=7 from the next cycle; B handshake to x7 in cycle N -> busy_A still 1 in N+1, 0 in N+2.
REQ-037 Same-edge collision: write_en to x9 while issue_en to x9 in the same cycle -> busy[9] remains 1.
REQ-038 x0 handling: handshake with a_addr=0 -> a_ready=1, write_en stays 0; issue_en to x0 -> issue_busy and busy_A for x0 remain 0.
REQ-039 Mid-operation reset: handshake in cycle N with rst=1 in N+1 -> write_en=0 in N+1 and N+2, busy vector all 0, next contention grants A first.
